// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: one requester's handshake into the shared RAM port arbiter
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              stall;
    modport master (output req, we, addr, wdata, input ack, rdata, stall);
    modport slave (input req, we, addr, wdata, output ack, rdata, stall);
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: 3-cycle RAM transactions shared CPU-first between CPU and host, with host starvation limit and halt
module ram_port_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    ram_port_arbiter_if.slave   cpu,
    ram_port_arbiter_if.slave   host,
    input  logic                host_halt,
    output logic                ram_en,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t            state_q, state_d;
    logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              cpu_ack_q, cpu_ack_d, host_ack_q, host_ack_d;
    logic              owner_q, owner_d;
    logic [3:0]        streak_q, streak_d;
    logic              cpu_ok, grant_host, grant_cpu;
    always_comb begin
        cpu_ok      = cpu.req & ~host_halt;
        grant_host  = host.req & (~cpu_ok | (streak_q == LIMIT));
        grant_cpu   = cpu_ok & ~grant_host;
        state_d     = state_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        cpu_ack_d   = 1'b0;
        host_ack_d  = 1'b0;
        owner_d     = owner_q;
        streak_d    = host.req ? streak_q : 4'd0;
        case (state_q)
            IDLE: if (grant_host | grant_cpu) begin
                state_d     = ACCESS;
                ram_en_d    = 1'b1;
                ram_we_d    = grant_host ? host.we : cpu.we;
                ram_addr_d  = grant_host ? host.addr : cpu.addr;
                ram_wdata_d = grant_host ? host.wdata : cpu.wdata;
                owner_d     = grant_host;
                // owner_q: 1 = host
                streak_d    = (grant_host | ~host.req) ? 4'd0 :
                              streak_q + ((streak_q == LIMIT) ? 4'd0 : 4'd1);
            end
            ACCESS: begin
                state_d    = RESP;
                cpu_ack_d  = ~owner_q;
                host_ack_d = owner_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            host_ack_q  <= 1'b0;
            owner_q     <= 1'b0;
            streak_q    <= 4'd0;
        end else begin
            state_q     <= state_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            host_ack_q  <= host_ack_d;
            owner_q     <= owner_d;
            streak_q    <= streak_d;
        end
    end
    assign ram_en     = ram_en_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign cpu.ack    = cpu_ack_q;
    assign cpu.rdata  = cpu_ack_q ? ram_rdata : '0;
    assign cpu.stall  = cpu.req & ~cpu_ack_q;
    assign host.ack   = host_ack_q;
    assign host.rdata = host_ack_q ? ram_rdata : '0;
    assign host.stall = host.req & ~host_ack_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed vectors, corner sequences and a randomized run against a cycle-budget reference model
module tb_ram_port_arbiter;
    localparam int LIM = 4;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        host_halt = 1'b0;
    logic        ram_en, ram_we;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata = 16'h0;
    logic [15:0] mem [256] = '{9: 16'h0007, default: 16'h0000};
    logic [15:0] mem_m [256];
    int checks = 0;
    int errors = 0;

    ram_port_arbiter_if #(.ADDR_W(8), .DATA_W(16)) cpu_if ();
    ram_port_arbiter_if #(.ADDR_W(8), .DATA_W(16)) host_if ();

    ram_port_arbiter #(.ADDR_W(8), .DATA_W(16), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset), .cpu(cpu_if), .host(host_if), .host_halt(host_halt),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    typedef struct {
        bit          host;
        bit          we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cpu_if.req = 0; cpu_if.we = 0; cpu_if.addr = 0; cpu_if.wdata = 0;
        host_if.req = 0; host_if.we = 0; host_if.addr = 0; host_if.wdata = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        host_halt = 0;
        reset = 0;
        repeat (2) @(negedge clk);
        reset = 1;
    endtask

    task automatic txn(input vec_t v);
        if (v.host) begin
            host_if.req = 1; host_if.we = v.we; host_if.addr = v.addr; host_if.wdata = v.wdata;
        end else begin
            cpu_if.req = 1; cpu_if.we = v.we; cpu_if.addr = v.addr; cpu_if.wdata = v.wdata;
        end
        @(negedge clk);
        chk("txn_ram_en", 32'(ram_en), 1);
        chk("txn_ram_addr", 32'(ram_addr), 32'(v.addr));
        chk("txn_ram_we", 32'(ram_we), 32'(v.we));
        @(negedge clk);
        chk("txn_cpu_ack", 32'(cpu_if.ack), 32'(!v.host));
        chk("txn_host_ack", 32'(host_if.ack), 32'(v.host));
        if (!v.we) chk("txn_rdata", 32'(v.host ? host_if.rdata : cpu_if.rdata), 32'(v.rdata));
        cpu_if.req = 0;
        host_if.req = 0;
        @(negedge clk);
        chk("txn_ack_clear", 32'({cpu_if.ack, host_if.ack}), 0);
        chk("txn_rdata_zero", 32'({cpu_if.rdata, host_if.rdata}), 0);
    endtask

    // host requests use address 0x20 so the granted side is visible on ram_addr
    task automatic next_grant(output int who);
        who = -1;
        for (int i = 0; i < 12 && who < 0; i++) begin
            @(negedge clk);
            if (ram_en) who = (ram_addr == 8'h20) ? 1 : 0;
        end
    endtask

    initial begin
        vec_t vt [6];
        int w;
        int ph, streak_m;
        bit ce, t_host, t_we;
        logic [7:0] t_addr;
        logic [15:0] t_wdata, t_rd;
        bit exp_en, exp_cack, exp_hack;
        vt[0] = '{1'b0, 1'b0, 8'h09, 16'h0000, 16'h0007};
        vt[1] = '{1'b1, 1'b1, 8'h03, 16'h1234, 16'h0000};
        vt[2] = '{1'b1, 1'b0, 8'h03, 16'h0000, 16'h1234};
        vt[3] = '{1'b0, 1'b1, 8'h40, 16'hBEEF, 16'h0000};
        vt[4] = '{1'b0, 1'b0, 8'h40, 16'h0000, 16'hBEEF};
        vt[5] = '{1'b1, 1'b0, 8'h09, 16'h0000, 16'h0007};

        idle_inputs();
        repeat (2) @(negedge clk);
        chk("rst_ram_en", 32'(ram_en), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_ram_wdata", 32'(ram_wdata), 0);
        chk("rst_acks", 32'({cpu_if.ack, host_if.ack}), 0);
        chk("rst_rdata", 32'({cpu_if.rdata, host_if.rdata}), 0);
        reset = 1;

        for (int i = 0; i < 6; i++) txn(vt[i]);

        // starvation: CPU saturates, host must get every (LIM+1)th grant
        do_reset();
        cpu_if.req = 1; cpu_if.we = 0; cpu_if.addr = 8'h10;
        next_grant(w);
        chk("starve_first", 32'(w), 0);
        host_if.req = 1; host_if.we = 0; host_if.addr = 8'h20;
        for (int i = 0; i < 2 * (LIM + 1); i++) begin
            next_grant(w);
            chk("starve_seq", 32'(w), (i % (LIM + 1) == LIM) ? 1 : 0);
        end

        // host halt: CPU locked out, then granted next after release
        do_reset();
        host_halt = 1;
        cpu_if.req = 1; cpu_if.addr = 8'h10;
        host_if.req = 1; host_if.addr = 8'h20;
        for (int i = 0; i < 5; i++) begin
            next_grant(w);
            chk("halt_host_only", 32'(w), 1);
            chk("halt_cpu_stall", 32'(cpu_if.stall), 1);
        end
        host_halt = 0;
        next_grant(w);
        chk("halt_release_cpu", 32'(w), 0);

        // simultaneous first requests after reset
        do_reset();
        cpu_if.req = 1; cpu_if.addr = 8'h10;
        host_if.req = 1; host_if.addr = 8'h20;
        next_grant(w);
        chk("simul_cpu_first", 32'(w), 0);
        @(negedge clk);
        chk("simul_cpu_ack", 32'({cpu_if.ack, host_if.ack}), 32'b10);
        cpu_if.req = 0;
        next_grant(w);
        chk("simul_host_next", 32'(w), 1);
        @(negedge clk);
        chk("simul_host_ack", 32'({cpu_if.ack, host_if.ack}), 32'b01);
        host_if.req = 0;

        // reset lands during ACCESS of a CPU write
        do_reset();
        cpu_if.req = 1; cpu_if.we = 1; cpu_if.addr = 8'h05; cpu_if.wdata = 16'h00FF;
        @(negedge clk);
        chk("mid_rst_access", 32'(ram_en), 1);
        reset = 0;
        @(negedge clk);
        chk("mid_rst_mem", 32'(mem[5]), 32'h00FF);
        chk("mid_rst_acks", 32'({cpu_if.ack, host_if.ack}), 0);
        chk("mid_rst_ram", 32'({ram_en, ram_we}), 0);
        chk("mid_rst_addr", 32'(ram_addr), 0);
        chk("mid_rst_wdata", 32'(ram_wdata), 0);
        chk("mid_rst_rdata", 32'(cpu_if.rdata), 0);
        cpu_if.req = 0;
        reset = 1;
        @(negedge clk);
        chk("mid_rst_no_ack", 32'(cpu_if.ack), 0);

        // randomized run: model tracks cycles since grant and a shadow memory
        do_reset();
        mem_m = mem;
        ph = 0; streak_m = 0;
        t_host = 0; t_we = 0; t_addr = 0; t_wdata = 0; t_rd = 0;
        exp_en = 0; exp_cack = 0; exp_hack = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!cpu_if.req || exp_cack) begin
                cpu_if.req = $urandom_range(0, 3) != 0;
                cpu_if.we = 1'($urandom_range(0, 1));
                cpu_if.addr = 8'($urandom_range(0, 15));
                cpu_if.wdata = 16'($urandom);
            end
            if (!host_if.req || exp_hack) begin
                host_if.req = $urandom_range(0, 2) == 0;
                host_if.we = 1'($urandom_range(0, 1));
                host_if.addr = 8'($urandom_range(0, 15));
                host_if.wdata = 16'($urandom);
            end
            if ($urandom_range(0, 15) == 0) host_halt = ~host_halt;
            exp_en = 0; exp_cack = 0; exp_hack = 0;
            if (ph == 0) begin
                ce = cpu_if.req && !host_halt;
                if (host_if.req || ce) begin
                    t_host = host_if.req && (!ce || streak_m == LIM);
                    streak_m = t_host ? 0 : (host_if.req ? ((streak_m + 1 > LIM) ? LIM : streak_m + 1) : 0);
                    t_we = t_host ? host_if.we : cpu_if.we;
                    t_addr = t_host ? host_if.addr : cpu_if.addr;
                    t_wdata = t_host ? host_if.wdata : cpu_if.wdata;
                    exp_en = 1;
                    ph = 1;
                end
            end else if (ph == 1) begin
                if (t_we) mem_m[t_addr] = t_wdata;
                else t_rd = mem_m[t_addr];
                exp_cack = !t_host;
                exp_hack = t_host;
                ph = 2;
            end else ph = 0;
            if (!host_if.req) streak_m = 0;
            @(negedge clk);
            chk("rnd_ram_en", 32'(ram_en), 32'(exp_en));
            if (exp_en) begin
                chk("rnd_ram_addr", 32'(ram_addr), 32'(t_addr));
                chk("rnd_ram_we", 32'(ram_we), 32'(t_we));
                if (t_we) chk("rnd_ram_wdata", 32'(ram_wdata), 32'(t_wdata));
            end
            chk("rnd_cpu_ack", 32'(cpu_if.ack), 32'(exp_cack));
            chk("rnd_host_ack", 32'(host_if.ack), 32'(exp_hack));
            if (exp_cack && !t_we) chk("rnd_cpu_rdata", 32'(cpu_if.rdata), 32'(t_rd));
            if (exp_hack && !t_we) chk("rnd_host_rdata", 32'(host_if.rdata), 32'(t_rd));
            if (!exp_cack) chk("rnd_cpu_rdata_zero", 32'(cpu_if.rdata), 0);
            if (!exp_hack) chk("rnd_host_rdata_zero", 32'(host_if.rdata), 0);
            chk("rnd_cpu_stall", 32'(cpu_if.stall), 32'(cpu_if.req && !exp_cack));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
